// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   fetch_state_t  : fetch FSM states
//   FAULT_*        : fault cause encodings reported on FAULT_CAUSE
//   NOP_INST       : instruction presented on MEM_INST out of reset (addi x0,x0,0)
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Instruction words are 4-byte aligned.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Loadable up-counter with terminal-count compare.
//   clk, rst : clock and synchronous active-high reset
//   load     : restart the count at zero (has priority over en)
//   en       : advance the count by one
//   term     : terminal value to compare against
//   at_term  : high while the current count equals term
module fetch_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_term = (count_reg == term);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding the control unit.
// Fetches one 32-bit word at PC_ADDR over a REQ/RDY handshake, presents it on
// MEM_INST with a one-cycle INST_ENB strobe, then idles EXEC_CYCLES cycles
// while the rest of the CPU executes and updates the PC before fetching again.
// Misaligned PCs and memory timeouts latch a sticky fault until RST.
//   CLK, RST               : clock, synchronous active-high reset
//   RUN, PC_ADDR           : fetch enable and current PC
//   IMEM_REQ/ADDR/RDY/RDATA: instruction memory read port
//   MEM_INST, INST_ENB     : fetched instruction and its valid strobe
//   FETCH_BUSY             : fetch activity (not IDLE/FAULT)
//   FAULT, FAULT_CAUSE, FAULT_ADDR : sticky fault status
//   INST_COUNT             : instructions issued (wraps)
// All outputs are registered.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int EXEC_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [ADDR_W-1:0] PC_ADDR,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_RDY,
  input  logic [31:0]       IMEM_RDATA,
  output logic [31:0]       MEM_INST,
  output logic              INST_ENB,
  output logic              FETCH_BUSY,
  output logic              FAULT,
  output logic [1:0]        FAULT_CAUSE,
  output logic [ADDR_W-1:0] FAULT_ADDR,
  output logic [31:0]       INST_COUNT
);

  // The timer only ever counts to TIMEOUT-1 or EXEC_CYCLES-1.
  localparam int TIMER_MAX = (TIMEOUT > EXEC_CYCLES) ? TIMEOUT : EXEC_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);
  localparam logic [TIMER_W-1:0] TIMEOUT_TERM = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] EXEC_TERM    = TIMER_W'(EXEC_CYCLES - 1);

  fetch_state_t      state_reg, state_next;
  logic              imem_req_reg, imem_req_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       mem_inst_reg, mem_inst_next;
  logic              inst_enb_reg, inst_enb_next;
  logic              fetch_busy_reg, fetch_busy_next;
  logic              fault_reg, fault_next;
  logic [1:0]        fault_cause_reg, fault_cause_next;
  logic [ADDR_W-1:0] fault_addr_reg, fault_addr_next;
  logic [31:0]       inst_count_reg, inst_count_next;

  logic              transfer;
  logic              pc_ok;
  logic              timer_load;
  logic              timer_en;
  logic              timer_at_term;
  logic [TIMER_W-1:0] timer_term;

  // RDY outside an outstanding request is ignored.
  assign transfer = (state_reg == ST_REQ) && imem_req_reg && IMEM_RDY;
  assign pc_ok    = pc_aligned(PC_ADDR[1:0]);

  // One timer serves both the REQ timeout and the EXEC wait; any state change
  // restarts it so each phase counts from zero.
  assign timer_load = (state_next != state_reg);
  assign timer_en   = ((state_reg == ST_REQ) && !transfer) || (state_reg == ST_EXEC);
  assign timer_term = (state_reg == ST_EXEC) ? EXEC_TERM : TIMEOUT_TERM;

  fetch_timer #(.W(TIMER_W)) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .load    (timer_load),
    .en      (timer_en),
    .term    (timer_term),
    .at_term (timer_at_term)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= '0;
      mem_inst_reg    <= NOP_INST;
      inst_enb_reg    <= 1'b0;
      fetch_busy_reg  <= 1'b0;
      fault_reg       <= 1'b0;
      fault_cause_reg <= FAULT_NONE;
      fault_addr_reg  <= '0;
      inst_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      imem_req_reg    <= imem_req_next;
      imem_addr_reg   <= imem_addr_next;
      mem_inst_reg    <= mem_inst_next;
      inst_enb_reg    <= inst_enb_next;
      fetch_busy_reg  <= fetch_busy_next;
      fault_reg       <= fault_next;
      fault_cause_reg <= fault_cause_next;
      fault_addr_reg  <= fault_addr_next;
      inst_count_reg  <= inst_count_next;
    end
  end

  // Next-state logic. RUN dropping during REQ does not abort the transfer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (RUN) state_next = pc_ok ? ST_REQ : ST_FAULT;
      end
      ST_REQ: begin
        if (transfer)           state_next = ST_ISSUE;
        else if (timer_at_term) state_next = ST_FAULT;
      end
      ST_ISSUE: state_next = ST_EXEC;
      ST_EXEC: begin
        // PC is sampled on the last EXEC cycle, after the CU has updated it.
        if (timer_at_term) begin
          if (RUN) state_next = pc_ok ? ST_REQ : ST_FAULT;
          else     state_next = ST_IDLE;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output-register next values, derived from the transition being taken.
  always_comb begin
    imem_req_next    = imem_req_reg;
    imem_addr_next   = imem_addr_reg;
    mem_inst_next    = mem_inst_reg;
    inst_enb_next    = inst_enb_reg;
    fault_next       = fault_reg;
    fault_cause_next = fault_cause_reg;
    fault_addr_next  = fault_addr_reg;
    inst_count_next  = inst_count_reg;
    fetch_busy_next  = (state_next != ST_IDLE) && (state_next != ST_FAULT);

    if ((state_next == ST_REQ) && (state_reg != ST_REQ)) begin
      imem_req_next  = 1'b1;
      imem_addr_next = PC_ADDR;
    end

    if (transfer) begin
      mem_inst_next   = IMEM_RDATA;
      imem_req_next   = 1'b0;
      inst_enb_next   = 1'b1;
      inst_count_next = inst_count_reg + 32'd1;
    end

    if (state_reg == ST_ISSUE) begin
      inst_enb_next = 1'b0;
    end

    if ((state_next == ST_FAULT) && (state_reg != ST_FAULT)) begin
      fault_next    = 1'b1;
      imem_req_next = 1'b0;
      inst_enb_next = 1'b0;
      if (state_reg == ST_REQ) begin
        fault_cause_next = FAULT_TIMEOUT;
        fault_addr_next  = imem_addr_reg;
      end else begin
        fault_cause_next = FAULT_MISALIGN;
        fault_addr_next  = PC_ADDR;
      end
    end
  end

  assign IMEM_REQ    = imem_req_reg;
  assign IMEM_ADDR   = imem_addr_reg;
  assign MEM_INST    = mem_inst_reg;
  assign INST_ENB    = inst_enb_reg;
  assign FETCH_BUSY  = fetch_busy_reg;
  assign FAULT       = fault_reg;
  assign FAULT_CAUSE = fault_cause_reg;
  assign FAULT_ADDR  = fault_addr_reg;
  assign INST_COUNT  = inst_count_reg;

endmodule
